alu_exec_stage: RTL and testbench

//   Execute stage of the ALU datapath: accepts an opcode and two operands over a

---
 rtl/alu_exec_stage.sv | 178 +++++++++++++++++
 tb/tb_alu_exec_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage
//   Execute stage of the ALU datapath. Takes an opcode and two operands over a
//   valid/ready handshake. Single-cycle ops finish on the accept edge. MUL runs
//   as an iterative shift-add multiply with one partial-product step per cycle.
//   The result is held until the downstream capture register takes it.
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      synchronous reset, active-low
//   i_in_valid   upstream presents op/a/b
//   o_in_ready   stage can accept (IDLE)
//   i_op         opcode: ADD SUB AND OR XOR SHL MUL PASS (000..111)
//   i_a, i_b     operands, SIZE bits
//   o_out_valid  result/carry/zero valid (DONE)
//   i_out_ready  downstream consumes result this cycle
//   o_result     registered result
//   o_carry      registered carry / borrow / MUL overflow
//   o_zero       registered (result == 0)
//   o_busy       multiply in progress (EXEC)
module alu_exec_stage #(
   parameter int unsigned SIZE = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [2:0]      i_op,
   input  logic [SIZE-1:0] i_a,
   input  logic [SIZE-1:0] i_b,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [SIZE-1:0] o_result,
   output logic            o_carry,
   output logic            o_zero,
   output logic            o_busy
);

   localparam logic [2:0] OpAdd  = 3'b000;
   localparam logic [2:0] OpSub  = 3'b001;
   localparam logic [2:0] OpAnd  = 3'b010;
   localparam logic [2:0] OpOr   = 3'b011;
   localparam logic [2:0] OpXor  = 3'b100;
   localparam logic [2:0] OpShl  = 3'b101;
   localparam logic [2:0] OpMul  = 3'b110;
   localparam logic [2:0] OpPass = 3'b111;

   localparam int unsigned CntW = $clog2(SIZE + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(SIZE - 1);

   typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

   state_e              r_state;
   state_e              w_state_next;

   logic [SIZE-1:0]     r_result;
   logic                r_carry;
   logic                r_zero;

   logic [2*SIZE-1:0]   r_mcand;
   logic [SIZE-1:0]     r_mplier;
   logic [2*SIZE-1:0]   r_prod;
   logic [CntW-1:0]     r_cnt;

   logic                w_accept;
   logic                w_last;
   logic [SIZE:0]       w_add;
   logic [SIZE:0]       w_sub;
   logic [SIZE-1:0]     w_alu_res;
   logic                w_alu_cy;
   logic [2*SIZE-1:0]   w_prod_step;

   assign w_accept    = i_in_valid & o_in_ready;
   assign w_last      = (r_cnt == LastCnt);
   assign w_add       = {1'b0, i_a} + {1'b0, i_b};
   // Top bit of the widened difference is the unsigned borrow.
   assign w_sub       = {1'b0, i_a} - {1'b0, i_b};
   assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

   // Single-cycle ops; MUL result comes from the iterative path instead.
   always_comb begin
      w_alu_res = '0;
      w_alu_cy  = 1'b0;
      case (i_op)
         OpAdd:  begin w_alu_res = w_add[SIZE-1:0]; w_alu_cy = w_add[SIZE]; end
         OpSub:  begin w_alu_res = w_sub[SIZE-1:0]; w_alu_cy = w_sub[SIZE]; end
         OpAnd:  w_alu_res = i_a & i_b;
         OpOr:   w_alu_res = i_a | i_b;
         OpXor:  w_alu_res = i_a ^ i_b;
         OpShl:  begin w_alu_res = {i_a[SIZE-2:0], 1'b0}; w_alu_cy = i_a[SIZE-1]; end
         OpPass: w_alu_res = i_a;
         default: begin w_alu_res = '0; w_alu_cy = 1'b0; end
      endcase
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_state_next = (i_op == OpMul) ? StExec : StDone;
            end
         end
         StExec: begin
            if (w_last) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            if (i_out_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         StIdle:  o_in_ready  = 1'b1;
         StExec:  o_busy      = 1'b1;
         StDone:  o_out_valid = 1'b1;
         default: o_in_ready  = 1'b0;
      endcase
   end

   // Datapath: result bank and shift-add multiplier
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_prod   <= '0;
         r_mcand  <= {{SIZE{1'b0}}, i_a};
         r_mplier <= i_b;
         if (i_op != OpMul) begin
            r_result <= w_alu_res;
            r_carry  <= w_alu_cy;
            r_zero   <= (w_alu_res == '0);
         end
      end else if (r_state == StExec) begin
         r_prod   <= w_prod_step;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         if (w_last) begin
            r_result <= w_prod_step[SIZE-1:0];
            r_carry  <= |w_prod_step[2*SIZE-1:SIZE];
            r_zero   <= (w_prod_step[SIZE-1:0] == '0);
         end else begin
            // Saturates at the last step; cleared again on the next accept.
            r_cnt <= r_cnt + CntW'(1);
         end
      end
   end

   assign o_result = r_result;
   assign o_carry  = r_carry;
   assign o_zero   = r_zero;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage (SIZE=8): directed cases with literal
// expectations plus a randomized run, all checked every cycle against a
// transaction-level model.
module tb_alu_exec_stage;

   localparam int SIZE = 8;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      op;
   logic [SIZE-1:0] a;
   logic [SIZE-1:0] b;
   logic            out_valid;
   logic            out_ready;
   logic [SIZE-1:0] result;
   logic            carry;
   logic            zero;
   logic            busy;

   int total = 0;
   int bad   = 0;

   alu_exec_stage #(.SIZE(SIZE)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_op        (op),
      .i_a         (a),
      .i_b         (b),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_result    (result),
      .o_carry     (carry),
      .o_zero      (zero),
      .o_busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference arithmetic in plain integers.
   function automatic void ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] r, output logic c);
      int unsigned p;
      c = 1'b0;
      case (o)
         3'd0: begin p = int'(x) + int'(y); r = 8'(p % 256); c = (p > 255); end
         3'd1: begin r = 8'((int'(x) - int'(y) + 256) % 256); c = (x < y); end
         3'd2: r = x & y;
         3'd3: r = x | y;
         3'd4: r = x ^ y;
         3'd5: begin r = 8'((int'(x) * 2) % 256); c = (x >= 8'd128); end
         3'd6: begin p = int'(x) * int'(y); r = 8'(p % 256); c = (p > 255); end
         default: r = x;
      endcase
   endfunction

   // Model: phase 0=idle 1=multiplying 2=holding result.
   int         m_ph = 0;
   int         m_left = 0;
   bit         m_known = 0;
   logic [7:0] m_res = '0;
   logic       m_cy = 1'b0;
   logic       m_zero = 1'b0;
   logic [7:0] m_pend_r;
   logic       m_pend_c;

   // Inputs change 1 time unit after posedge, so at negedge they are the
   // values the next edge will sample.
   initial begin
      forever begin
         @(negedge clk);
         if (m_known) begin
            chk("in_ready", in_ready, m_ph == 0);
            chk("out_valid", out_valid, m_ph == 2);
            chk("busy", busy, m_ph == 1);
            chk("result", result, m_res);
            chk("carry", carry, m_cy);
            chk("zero", zero, m_zero);
         end
         if (!rst_n) begin
            m_known = 1; m_ph = 0; m_res = '0; m_cy = 0; m_zero = 0;
         end else if (m_known) begin
            case (m_ph)
               0: if (in_valid) begin
                  ref_op(op, a, b, m_pend_r, m_pend_c);
                  if (op == 3'd6) begin
                     m_ph = 1; m_left = SIZE;
                  end else begin
                     m_ph = 2; m_res = m_pend_r; m_cy = m_pend_c; m_zero = (m_pend_r == 0);
                  end
               end
               1: begin
                  m_left--;
                  if (m_left == 0) begin
                     m_ph = 2; m_res = m_pend_r; m_cy = m_pend_c; m_zero = (m_pend_r == 0);
                  end
               end
               default: if (out_ready) m_ph = 0;
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one cycle; caller ensures the stage is idle.
   task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      op = o; a = x; b = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
   endtask

   // Edges from accept until out_valid, and cycles busy was seen meanwhile.
   task automatic wait_done(output int lat, output int nbusy);
      lat = 1; nbusy = 0;
      while (!out_valid && lat < 40) begin
         if (busy) nbusy++;
         tick();
         lat++;
      end
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pop_in_ready", in_ready, 1);
      chk("pop_out_valid", out_valid, 0);
   endtask

   task automatic expect_res(input string name, input logic [7:0] r, input logic c, input logic z);
      chk({name, "_res"}, result, r);
      chk({name, "_carry"}, carry, c);
      chk({name, "_zero"}, zero, z);
   endtask

   initial begin
      int lat;
      int nb;
      logic [7:0] pr;
      logic pc;

      rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;

      // Pin the model itself.
      ref_op(3'd0, 8'hF0, 8'h20, pr, pc); chk("model_add", {pc, pr}, {1'b1, 8'h10});
      ref_op(3'd1, 8'h03, 8'h04, pr, pc); chk("model_sub", {pc, pr}, {1'b1, 8'hFF});
      ref_op(3'd6, 8'h0F, 8'h11, pr, pc); chk("model_mul", {pc, pr}, {1'b0, 8'hFF});
      ref_op(3'd6, 8'h10, 8'h10, pr, pc); chk("model_mulov", {pc, pr}, {1'b1, 8'h00});
      ref_op(3'd5, 8'h81, 8'h00, pr, pc); chk("model_shl", {pc, pr}, {1'b1, 8'h02});

      tick(); tick();
      rst_n = 1'b1;
      expect_res("reset", 8'h00, 1'b0, 1'b0);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);

      // ADD with carry-out
      send(3'd0, 8'hF0, 8'h20);
      wait_done(lat, nb);
      chk("add_latency", lat, 1);
      expect_res("add", 8'h10, 1'b1, 1'b0);
      pop();

      // SUB equal and borrow
      send(3'd1, 8'h05, 8'h05); wait_done(lat, nb);
      expect_res("sub_eq", 8'h00, 1'b0, 1'b1); pop();
      send(3'd1, 8'h03, 8'h04); wait_done(lat, nb);
      expect_res("sub_borrow", 8'hFF, 1'b1, 1'b0); pop();

      // MUL latency and overflow
      send(3'd6, 8'h0F, 8'h11); wait_done(lat, nb);
      chk("mul_latency", lat, 9);
      chk("mul_busy_cycles", nb, 8);
      expect_res("mul", 8'hFF, 1'b0, 1'b0); pop();
      send(3'd6, 8'h10, 8'h10); wait_done(lat, nb);
      expect_res("mul_ov", 8'h00, 1'b1, 1'b1); pop();

      // Backpressure: result held, stray in_valid ignored
      send(3'd0, 8'h01, 8'h01); wait_done(lat, nb);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom); op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
         tick();
         chk("stall_res", result, 8'h02);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_in_ready", in_ready, 0);
      end
      in_valid = 1'b0;
      pop();

      // Reset during 4th EXEC cycle
      send(3'd6, 8'hFF, 8'hFF);
      tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      expect_res("midreset", 8'h00, 1'b0, 1'b0);
      chk("midreset_busy", busy, 0);
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_in_ready", in_ready, 1);
      send(3'd4, 8'hAA, 8'hFF); wait_done(lat, nb);
      expect_res("xor", 8'h55, 1'b0, 1'b0); pop();

      // Opcode sweep
      send(3'd5, 8'h81, 8'h00); wait_done(lat, nb);
      expect_res("shl", 8'h02, 1'b1, 1'b0); pop();
      send(3'd7, 8'h00, 8'h5A); wait_done(lat, nb);
      expect_res("pass", 8'h00, 1'b0, 1'b1); pop();
      send(3'd2, 8'hC3, 8'h3C); wait_done(lat, nb);
      expect_res("and", 8'h00, 1'b0, 1'b1); pop();
      send(3'd3, 8'hC3, 8'h3C); wait_done(lat, nb);
      expect_res("or", 8'hFF, 1'b0, 1'b0); pop();

      // Randomized traffic, including occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 149) != 0);
         in_valid  = 1'($urandom);
         op        = 3'($urandom);
         a         = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         b         = ($urandom_range(0, 7) == 0) ? 8'h00 :
                     ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick();
      end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick(); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
